// File: rtl/fp_pack_norm.sv
// Normalize, round and pack a raw sign/exponent/mantissa into an IEEE-754 single word,
// one shift per cycle. Build option: define ROUND_NEAREST_EN for round-to-nearest-even, else truncate.
module fp_pack_norm #(
    parameter int unsigned MAN_W = 24,
    parameter int unsigned EXP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MAN_W:0]         man_in,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W-1:0] result,
    output logic                   ovf,
    output logic                   unf,
    output logic                   zero
);

    localparam int unsigned EW  = EXP_W + 1;
    localparam int unsigned MW  = MAN_W + 1;
    localparam int unsigned RW  = EXP_W + MAN_W;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

`ifdef ROUND_NEAREST_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        NORM  = 2'd2,
        ROUND = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   man_q, man_d;
    logic            rnd_q, rnd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [RW-1:0]   result_q, result_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            zero_q, zero_d;

    logic [EW-1:0]   eff_exp;
    logic [MW-1:0]   man_r;
    logic [EW-1:0]   exp_r;
    logic            rnd_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            man_q    <= '0;
            rnd_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            rnd_q    <= rnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        man_d    = man_q;
        rnd_d    = rnd_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;

        // A zero exponent denotes a denormal, which scales like exponent 1.
        eff_exp  = (exp_q == '0) ? EXP_ONE : exp_q;

        rnd_inc  = ROUND_EN & rnd_q & man_q[0];
        man_r    = man_q + MW'(rnd_inc);
        exp_r    = exp_q;
        if (man_r[MAN_W]) begin
            man_r = man_r >> 1;
            exp_r = exp_q + EW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sign_d  = sign_in;
                    exp_d   = EW'(exp_in);
                    man_d   = man_in;
                    rnd_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (man_q == '0) begin
                    result_d = {sign_q, (RW - 1)'(0)};
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (exp_q == EXP_MAX) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, (MAN_W - 1)'(0)};
                    zero_d   = 1'b0;
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (man_q[MAN_W]) begin
                    man_d   = man_q >> 1;
                    exp_d   = eff_exp + EW'(1);
                    rnd_d   = man_q[0];
                    state_d = ROUND;
                end else if (man_q[MAN_W-1] || eff_exp <= EXP_ONE) begin
                    exp_d   = eff_exp;
                    state_d = ROUND;
                end else begin
                    exp_d   = eff_exp;
                    state_d = NORM;
                end
            end
            NORM: begin
                // Stop at exponent 1 so an unreachable hidden bit ends up as a denormal.
                man_d = man_q << 1;
                exp_d = exp_q - EW'(1);
                if (man_d[MAN_W-1] || exp_d == EXP_ONE) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                zero_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (exp_r >= EXP_MAX) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, (MAN_W - 1)'(0)};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                end else if (!man_r[MAN_W-1]) begin
                    result_d = {sign_q, EXP_W'(0), man_r[MAN_W-2:0]};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-2:0]};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign zero   = zero_q;

endmodule
